// File: rtl/fir_pkg.sv
// Shared definitions for the FIR / deconvolution path.
// Holds the default coefficients, data widths, the deconvolver FSM state type
// and the saturating clamp used wherever an accumulator is narrowed to a sample.
package fir_pkg;

  localparam int X_W   = 8;   // recovered-sample width (signed)
  localparam int Y_W   = 16;  // filtered-sample width (signed)
  localparam int ACC_W = 20;  // accumulator width (signed)

  localparam logic signed [7:0] H1_DEF = 8'sd2;
  localparam logic signed [7:0] H2_DEF = 8'sd3;
  localparam logic signed [7:0] H3_DEF = 8'sd4;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  typedef enum logic [2:0] {
    StIdle,
    StMac1,
    StMac2,
    StMac3,
    StDone
  } state_e;

  typedef struct packed {
    logic signed [X_W-1:0] val;
    logic                  clip;
  } sat_t;

  // Clamp an accumulator value to the signed 8-bit range and flag clipping.
  function automatic sat_t sat8(input logic signed [ACC_W-1:0] r);
    sat_t s;
    if (r > SAT_HI) begin
      s.val  = 8'sd127;
      s.clip = 1'b1;
    end else if (r < SAT_LO) begin
      s.val  = -8'sd128;
      s.clip = 1'b1;
    end else begin
      s.val  = r[X_W-1:0];
      s.clip = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/fir_deconv_if.sv
// Stream bundle for fir_deconv: filtered samples in, recovered samples out.
//   y_in/in_valid/in_ready       : input handshake (filtered sample)
//   x_out/sat/out_valid/out_ready: output handshake (recovered sample + clip flag)
// Modport slave is the block's view; master is the surrounding environment.
interface fir_deconv_if;
  import fir_pkg::*;

  logic signed [Y_W-1:0] y_in;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [X_W-1:0] x_out;
  logic                  sat;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  y_in, in_valid, out_ready,
    output in_ready, x_out, sat, out_valid
  );

  modport master (
    output y_in, in_valid, out_ready,
    input  in_ready, x_out, sat, out_valid
  );

endinterface

// File: rtl/fir_sat.sv
// Saturating clamp from accumulator width to signed 8-bit sample.
// Kept as its own block so the FIR output rounding stage can share it.
//   r    : accumulator value (signed, ACC_W)
//   x    : clamped sample (signed, X_W)
//   clip : r was outside [-128, 127]
module fir_sat
  import fir_pkg::*;
(
  input  logic signed [ACC_W-1:0] r,
  output logic signed [X_W-1:0]   x,
  output logic                    clip
);

  sat_t s;

  assign s    = sat8(r);
  assign x    = s.val;
  assign clip = s.clip;

endmodule

// File: rtl/fir_deconv.sv
// Inverse filter for the 4-tap FIR path (h0 = 1):
//   x[n] = y[n] - H1*x[n-1] - H2*x[n-2] - H3*x[n-3]
// One shared 8x8 multiplier walks the three taps under FSM control, one sample
// per four cycles. History stores the saturated outputs.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   clr   : synchronous clear (abort, zero history), below reset in priority
//   bus   : slave side of the stream bundle (y_in in, x_out/sat out)
module fir_deconv
  import fir_pkg::*;
#(
  parameter logic signed [7:0] H1 = H1_DEF,
  parameter logic signed [7:0] H2 = H2_DEF,
  parameter logic signed [7:0] H3 = H3_DEF
) (
  input logic         clk,
  input logic         reset,
  input logic         clr,
  fir_deconv_if.slave bus
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [X_W-1:0]   x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic signed [X_W-1:0]   x_out_q, x_out_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [7:0]       coef;
  logic signed [X_W-1:0]   tap;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] diff;
  logic signed [ACC_W-1:0] y_ext;
  logic signed [X_W-1:0]   r_sat;
  logic                    r_clip;
  logic                    accept;

  // Coefficient and history tap for the single multiplier, selected by state.
  always_comb begin
    coef = '0;
    tap  = '0;
    case (state_q)
      StMac1: begin
        coef = H1;
        tap  = x1_q;
      end
      StMac2: begin
        coef = H2;
        tap  = x2_q;
      end
      StMac3: begin
        coef = H3;
        tap  = x3_q;
      end
      default: ;
    endcase
  end

  assign prod  = coef * tap;
  assign diff  = acc_q - ACC_W'(prod);
  assign y_ext = ACC_W'(bus.y_in);

  fir_sat u_sat (
    .r    (diff),
    .x    (r_sat),
    .clip (r_clip)
  );

  assign bus.in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  // clr blocks acceptance even though in_ready may read 1.
  assign accept       = bus.in_valid && bus.in_ready && !clr;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    x_out_d     = x_out_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      state_d     = StIdle;
      acc_d       = '0;
      x1_d        = '0;
      x2_d        = '0;
      x3_d        = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            acc_d   = y_ext;
            state_d = StMac1;
          end
        end
        StMac1: begin
          acc_d   = diff;
          state_d = StMac2;
        end
        StMac2: begin
          acc_d   = diff;
          state_d = StMac3;
        end
        StMac3: begin
          x_out_d     = r_sat;
          sat_d       = r_clip;
          x3_d        = x2_q;
          x2_d        = x1_q;
          x1_d        = r_sat;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            if (accept) begin
              acc_d   = y_ext;
              state_d = StMac1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      x_out_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      x_out_q     <= x_out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.x_out     = x_out_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_deconv.sv
module tb_fir_deconv;

  localparam int C1 = 2;
  localparam int C2 = 3;
  localparam int C3 = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic clr   = 1'b0;

  fir_deconv_if bus ();

  fir_deconv dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: recursion on plain integers, one entry per accepted sample.
  int hm1 = 0, hm2 = 0, hm3 = 0;
  int exp_x[$];
  bit exp_s[$];
  int exp_t[$];
  int got_x[$];
  bit got_s[$];
  int acc_log[$];
  bit prev_ov = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_accept(input int y, input int t);
    int r;
    int xs;
    bit s;
    r = y - C1 * hm1 - C2 * hm2 - C3 * hm3;
    if (r > 127) begin
      xs = 127;
      s  = 1'b1;
    end else if (r < -128) begin
      xs = -128;
      s  = 1'b1;
    end else begin
      xs = r;
      s  = 1'b0;
    end
    hm3 = hm2;
    hm2 = hm1;
    hm1 = xs;
    exp_x.push_back(xs);
    exp_s.push_back(s);
    exp_t.push_back(t);
  endfunction

  function automatic void model_clear();
    hm1 = 0;
    hm2 = 0;
    hm3 = 0;
    exp_x.delete();
    exp_s.delete();
    exp_t.delete();
  endfunction

  // Compare process: every cycle the output is valid it must match the model head.
  always @(negedge clk) begin
    if (!reset) begin
      model_clear();
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid === 1'b1) begin
        if (exp_x.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          check("x_out", int'(bus.x_out), exp_x[0]);
          check("sat", int'(bus.sat), int'(exp_s[0]));
          if (!prev_ov) check("latency", cyc - exp_t[0], 3);
          if (bus.out_ready && !clr) begin
            got_x.push_back(int'(bus.x_out));
            got_s.push_back(bus.sat);
            void'(exp_x.pop_front());
            void'(exp_s.pop_front());
            void'(exp_t.pop_front());
          end
        end
      end
      prev_ov = (bus.out_valid === 1'b1);
      if (clr) begin
        model_clear();
      end else if (bus.in_valid && bus.in_ready) begin
        model_accept(int'(bus.y_in), cyc + 1);
        acc_log.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input int y);
    bit ok;
    bus.y_in     = 16'(y);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = bus.in_ready && !clr;
      @(posedge clk);
      #1;
      if (ok) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 200 && got_x.size() < n; i++) @(posedge clk);
    #1;
    check("outputs_seen", got_x.size(), n);
  endtask

  task automatic clear_logs();
    got_x.delete();
    got_s.delete();
    acc_log.delete();
  endtask

  task automatic expect_got(input string name, input int idx, input int x, input int s);
    if (idx < got_x.size()) begin
      check(name, got_x[idx], x);
      check({name, "_sat"}, int'(got_s[idx]), s);
    end
  endtask

  int imp[5] = '{1, 0, 0, 0, 0};
  int imp_y[5] = '{1, 2, 3, 4, 0};
  int stp_y[5] = '{10, 30, 60, 100, 100};

  initial begin
    bus.y_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_x_out", int'(bus.x_out), 0);
    check("reset_sat", int'(bus.sat), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Impulse
    clear_logs();
    for (int i = 0; i < 5; i++) send(imp_y[i]);
    wait_got(5);
    for (int i = 0; i < 5; i++) expect_got("impulse", i, imp[i], 0);

    // Step, with handshake spacing
    clear_logs();
    for (int i = 0; i < 5; i++) send(stp_y[i]);
    wait_got(5);
    for (int i = 0; i < 5; i++) expect_got("step", i, 10, 0);
    for (int i = 1; i < 5 && i < acc_log.size(); i++)
      check("step_spacing", acc_log[i] - acc_log[i-1], 4);

    // Clear zeroes the history
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    clear_logs();
    send(7);
    wait_got(1);
    expect_got("after_clr", 0, 7, 0);

    // Saturation after reset
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    clear_logs();
    send(200);
    send(0);
    wait_got(2);
    expect_got("sat_hi", 0, 127, 1);
    expect_got("sat_lo", 1, -128, 1);

    // Backpressure: history is -128, 127, 0 -> 50 + 256 - 381 = -75
    clear_logs();
    bus.out_ready = 1'b0;
    send(50);
    for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_x_out", int'(bus.x_out), -75);
    end
    bus.y_in      = 16'(9);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check("bp_release_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_out_valid_drop", int'(bus.out_valid), 0);
    wait_got(2);
    expect_got("bp_first", 0, -75, 0);
    expect_got("bp_next", 1, 35, 0);  // 9 + 150 + 384 - 508

    // Reset while in MAC2
    send(33);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_x_out", int'(bus.x_out), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    clear_logs();
    send(5);
    wait_got(1);
    expect_got("after_reset", 0, 5, 0);

    // Randomized traffic, backpressure and occasional clears
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.y_in      = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                  : 16'($urandom_range(0, 600) - 300);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      clr           = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    clr           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("drain", exp_x.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_deconv.md
Name: fir_deconv

Overview:
Inverse (deconvolution) filter for the 4-tap FIR path. It recovers the original 8-bit sample stream from the 16-bit filtered stream by solving x[n] = y[n] - H1*x[n-1] - H2*x[n-2] - H3*x[n-3], with h0 fixed at 1. It sits at the receive end of the filtered link. It uses a single time-multiplexed multiplier under FSM control, with valid/ready handshakes on both sides.

Parameters:
H1, 2, signed 8-bit coefficient for tap 1
H2, 3, signed 8-bit coefficient for tap 2
H3, 4, signed 8-bit coefficient for tap 3
X_W, 8, recovered-sample width (signed)
Y_W, 16, filtered-sample input width (signed)
ACC_W, 20, accumulator width (signed; covers Y_W + 8x8 products, three terms)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset (asserted when 0)
clr  in  1  synchronous clear: abort operation, zero history
y_in  in  Y_W  filtered sample, signed
in_valid  in  1  y_in valid
in_ready  out  1  block can accept y_in
x_out  out  X_W  recovered sample, signed, saturated
sat  out  1  x_out was clipped (qualified by out_valid)
out_valid  out  1  x_out/sat valid
out_ready  in  1  downstream accepts x_out

Behaviour:
- Reset (reset=0, async): state=IDLE, acc=0, history x1=x2=x3=0, x_out=0, sat=0, out_valid=0.
- Reset has priority over everything. Asserting it mid-operation discards the in-flight sample; no output is produced for that sample.
- in_ready is combinational: 1 when state==IDLE, or when state==DONE && out_ready.
- FSM states: IDLE, MAC1, MAC2, MAC3, DONE.
- Accept: on an edge with in_valid && in_ready, acc <= sign-extend(y_in) and state -> MAC1.
- MAC1: acc <= acc - H1*x1; state -> MAC2.
- MAC2: acc <= acc - H2*x2; state -> MAC3.
- MAC3: r = acc - H3*x3, computed at ACC_W.
  - x_out <= sat8(r); sat <= (r > 127 or r < -128).
  - History shifts: x3<=x2, x2<=x1, x1<=sat8(r).
  - out_valid <= 1; state -> DONE.
- Exactly one multiplier is used, with coefficient and history tap muxed by state. All products are signed 8x8 -> 16, sign-extended to ACC_W.
- Latency: out_valid rises on the 4th edge after (and including) the accept edge. Output is registered.
- DONE: x_out, sat and out_valid hold stable while out_ready=0; in_ready=0 during this time.
- Output handshake: on an edge with out_ready=1:
  - If in_valid=1, the next sample is accepted on the same edge: acc loaded, state -> MAC1, out_valid <= 0.
  - Else out_valid <= 0 and state -> IDLE.
- Throughput: 1 sample per 4 cycles with continuous valid/ready.
- History holds saturated values, so a clipped sample propagates as clipped. This is intended.
- clr=1, synchronous, priority below reset and above all else: state -> IDLE, history zeroed, out_valid <= 0, sat <= 0, acc <= 0. While clr=1 no sample is accepted, even though in_ready may read 1.
- in_valid while not ready: the input is ignored, not buffered.

Decomposition:
- Shared package fir_pkg holds:
  - default coefficients H1..H3 and widths X_W, Y_W, ACC_W;
  - the FSM state enum (IDLE, MAC1, MAC2, MAC3, DONE);
  - a sat8 function (ACC_W -> 8-bit signed clamp plus flag).
- One natural sub-module, fir_sat, wraps the saturating clamp so the future FIR-output rounding stage can reuse it.
- The FSM, multiplier mux and history stay in fir_deconv.

Test Plan:
- Impulse: reset, then y_in = 1,2,3,4,0 with out_ready=1 -> x_out = 1,0,0,0,0, sat=0 on every output.
- Step: y_in = 10,30,60,100,100 -> x_out = 10,10,10,10,10; successive in_valid/in_ready handshakes are exactly 4 cycles apart.
- Saturation: after reset, y_in = 200 then 0 -> x_out=127 sat=1, then x_out=-128 sat=1 (0 - 2*127 = -254 clipped).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1, x_out stable, in_ready=0 throughout. Raise out_ready with in_valid=1 -> accept on the same edge, out_valid=0 the next cycle.
- Reset mid-operation: drive reset=0 while in MAC2 -> out_valid=0 and x_out=0 immediately (async). After release, y_in=5 -> x_out=5, proving the history was zeroed.
- Clear: after the step sequence, pulse clr=1 for 1 cycle, then y_in=7 -> x_out=7, not 7-20-30-40.
